// File: rtl/mas_pkg.sv
// ---------------------------------------------------------------------------
// mas_pkg
// Shared encodings for the pipelined modular adder/subtractor (mas_pipe).
//   sel_e  : operation select (add, sub, accumulate-add, accumulate-load)
//   tcmp_e : range code of the raw result against the modulus
// Helpers classify an operation as an accumulator op and say whether it
// consumes operand 2.
// ---------------------------------------------------------------------------
package mas_pkg;

  typedef enum logic [1:0] {
    SEL_ADD      = 2'b00,
    SEL_SUB      = 2'b01,
    SEL_ACC_ADD  = 2'b10,
    SEL_ACC_LOAD = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    TCMP_IN = 2'b00,  // raw already in [0,q)
    TCMP_HI = 2'b01,  // raw >= q, subtract q
    TCMP_LO = 2'b10   // raw < 0, add q
  } tcmp_e;

  // True for the two operations that read or write the accumulator.
  function automatic logic is_acc_op(input logic [1:0] sel);
    return (sel == SEL_ACC_ADD) || (sel == SEL_ACC_LOAD);
  endfunction

  // Operand 2 only participates in plain add/sub.
  function automatic logic uses_din2(input logic [1:0] sel);
    return (sel == SEL_ADD) || (sel == SEL_SUB);
  endfunction

endpackage

// File: rtl/mas_pipe_if.sv
// ---------------------------------------------------------------------------
// mas_pipe_if
// Bus bundle for mas_pipe: input channel (valid/ready + operands, select,
// modulus, accumulator clear) and output channel (valid/ready + raw result,
// range code, corrected result, error flag, accumulator value).
//   slave  : view used by mas_pipe
//   master : view used by the block feeding/consuming mas_pipe
// ---------------------------------------------------------------------------
interface mas_pipe_if #(
  parameter int W = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   din1;
  logic [W-1:0]   din2;
  logic [1:0]     sel;
  logic [W-1:0]   q;
  logic           acc_clr;
  logic           out_valid;
  logic           out_ready;
  logic [W+1:0]   tdout;
  logic [1:0]     tcmp;
  logic [W-1:0]   dout;
  logic           out_err;
  logic [W-1:0]   acc_val;

  modport slave (
    input  in_valid, din1, din2, sel, q, acc_clr, out_ready,
    output in_ready, out_valid, tdout, tcmp, dout, out_err, acc_val
  );

  modport master (
    output in_valid, din1, din2, sel, q, acc_clr, out_ready,
    input  in_ready, out_valid, tdout, tcmp, dout, out_err, acc_val
  );
endinterface

// File: rtl/mod_correct.sv
// ---------------------------------------------------------------------------
// mod_correct
// Combinational single-step modular correction of a signed raw result.
//   raw  [W+1:0] in  : two's-complement raw sum/difference, range [-(q-1), 2q-2]
//   q    [W-1:0] in  : modulus
//   tcmp [1:0]   out : TCMP_IN / TCMP_HI / TCMP_LO
//   dout [W-1:0] out : raw, raw-q or raw+q, always in [0,q)
// The corrected value always fits in W bits, so the +/-q step is done on the
// low W bits only; the wrap-around of that W-bit arithmetic cancels out.
// ---------------------------------------------------------------------------
module mod_correct
  import mas_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W+1:0] raw,
  input  logic [W-1:0] q,
  output logic [1:0]   tcmp,
  output logic [W-1:0] dout
);

  // Classify raw against [0,q) and apply at most one correction step.
  always_comb begin
    tcmp = TCMP_IN;
    dout = raw[W-1:0];
    if (raw[W+1]) begin
      // Sign bit set: raw is negative.
      tcmp = TCMP_LO;
      dout = raw[W-1:0] + q;
    end else if (raw >= {2'b00, q}) begin
      // Non-negative here, so the unsigned compare is exact.
      tcmp = TCMP_HI;
      dout = raw[W-1:0] - q;
    end else begin
      tcmp = TCMP_IN;
      dout = raw[W-1:0];
    end
  end

endmodule

// File: rtl/mas_pipe.sv
// ---------------------------------------------------------------------------
// mas_pipe
// Two-stage valid/ready pipelined modular adder/subtractor with a running
// modular accumulator.
//   clk    in : clock
//   rst_n  in : synchronous active-low reset
//   bus       : mas_pipe_if.slave
//     in_valid/in_ready   input handshake
//     din1, din2, sel, q  operands, operation, modulus (sampled per op)
//     acc_clr             clear accumulator
//     out_valid/out_ready output handshake
//     tdout               signed raw result (W+2 bits)
//     tcmp                range code of raw vs q
//     dout                corrected result in [0,q)
//     out_err             operand/modulus violation for this transaction
//     acc_val             accumulator register
// Stage 1 registers the raw result; stage 2 registers the corrected result.
// Accumulator ops forward the stage-1 corrected value so back-to-back
// accumulate-adds see each preceding result without bubbles.
// ---------------------------------------------------------------------------
module mas_pipe
  import mas_pkg::*;
#(
  parameter int W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mas_pipe_if.slave   bus
);

  logic           adv_s;
  logic           accept_s;
  logic           fwd_s;
  logic [W-1:0]   acc_eff_s;
  logic [W+1:0]   raw_next_s;
  logic           err_next_s;

  logic           s1_valid_r;
  logic [W-1:0]   s1_q_r;
  logic           s1_acc_r;
  logic           s1_err_r;
  logic [W+1:0]   s1_raw_r;

  logic [1:0]     mc_tcmp_s;
  logic [W-1:0]   mc_dout_s;

  logic           out_valid_r;
  logic [W+1:0]   tdout_r;
  logic [1:0]     tcmp_r;
  logic [W-1:0]   dout_r;
  logic           out_err_r;
  logic [W-1:0]   acc_r;

  // The whole pipeline moves together; it only stalls when a result is
  // waiting and downstream refuses it.
  assign adv_s    = !out_valid_r || bus.out_ready;
  assign accept_s = bus.in_valid && adv_s;

  // A valid, error-free accumulator op leaving stage 1 this cycle updates acc.
  assign fwd_s = adv_s && s1_valid_r && !s1_err_r && s1_acc_r;

  // Accumulator value seen by an op being accepted now (clear and forwarding).
  always_comb begin
    acc_eff_s = acc_r;
    if (bus.acc_clr) begin
      acc_eff_s = '0;
    end else if (fwd_s) begin
      acc_eff_s = mc_dout_s;
    end else begin
      acc_eff_s = acc_r;
    end
  end

  // Raw W+2-bit result for the incoming operation (two's complement wrap
  // gives the signed difference directly).
  always_comb begin
    raw_next_s = {2'b00, bus.din1};
    case (bus.sel)
      SEL_ADD:      raw_next_s = {2'b00, bus.din1} + {2'b00, bus.din2};
      SEL_SUB:      raw_next_s = {2'b00, bus.din1} - {2'b00, bus.din2};
      SEL_ACC_ADD:  raw_next_s = {2'b00, acc_eff_s} + {2'b00, bus.din1};
      SEL_ACC_LOAD: raw_next_s = {2'b00, bus.din1};
      default:      raw_next_s = {2'b00, bus.din1};
    endcase
  end

  // Operand range check; din2 is don't-care for accumulator ops.
  always_comb begin
    err_next_s = 1'b0;
    if ((bus.din1 >= bus.q) || (bus.q < W'(2))) begin
      err_next_s = 1'b1;
    end else if (uses_din2(bus.sel) && (bus.din2 >= bus.q)) begin
      err_next_s = 1'b1;
    end else begin
      err_next_s = 1'b0;
    end
  end

  // Stage 1 register: raw result plus the context needed for correction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_q_r     <= '0;
      s1_acc_r   <= 1'b0;
      s1_err_r   <= 1'b0;
      s1_raw_r   <= '0;
    end else if (adv_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_q_r   <= bus.q;
        s1_acc_r <= is_acc_op(bus.sel);
        s1_err_r <= err_next_s;
        s1_raw_r <= raw_next_s;
      end
    end
  end

  mod_correct #(
    .W (W)
  ) u_mod_correct (
    .raw  (s1_raw_r),
    .q    (s1_q_r),
    .tcmp (mc_tcmp_s),
    .dout (mc_dout_s)
  );

  // Stage 2 register: corrected result; error transactions report 0 / in-range.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      tdout_r     <= '0;
      tcmp_r      <= TCMP_IN;
      dout_r      <= '0;
      out_err_r   <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        tdout_r   <= s1_raw_r;
        tcmp_r    <= s1_err_r ? TCMP_IN : mc_tcmp_s;
        dout_r    <= s1_err_r ? '0 : mc_dout_s;
        out_err_r <= s1_err_r;
      end
    end
  end

  // Accumulator: clear has priority over an accumulator op being captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (bus.acc_clr) begin
      acc_r <= '0;
    end else if (fwd_s) begin
      acc_r <= mc_dout_s;
    end
  end

  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_r;
  assign bus.tdout     = tdout_r;
  assign bus.tcmp      = tcmp_r;
  assign bus.dout      = dout_r;
  assign bus.out_err   = out_err_r;
  assign bus.acc_val   = acc_r;

endmodule

// File: tb/tb_mas_pipe.sv
// ---------------------------------------------------------------------------
// tb_mas_pipe
// Directed self-checking bench for mas_pipe with W=4. Inputs change and
// outputs are read on the falling edge of clk.
// ---------------------------------------------------------------------------
module tb_mas_pipe;
  import mas_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mas_pipe_if #(.W(4)) bus ();

  mas_pipe #(.W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic drive(input logic v, input logic [1:0] s,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] qq);
    bus.in_valid = v;
    bus.sel      = s;
    bus.din1     = a;
    bus.din2     = b;
    bus.q        = qq;
  endtask

  task automatic idle();
    drive(1'b0, SEL_ADD, 4'd0, 4'd0, 4'd13);
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0d exp=0", bus.out_valid); end
    checks++; if (bus.tdout !== 6'd0) begin errors++; $display("FAIL rst_tdout got=%0d exp=0", bus.tdout); end
    checks++; if (bus.tcmp !== 2'b00) begin errors++; $display("FAIL rst_tcmp got=%0b exp=00", bus.tcmp); end
    checks++; if (bus.dout !== 4'd0) begin errors++; $display("FAIL rst_dout got=%0d exp=0", bus.dout); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err got=%0d exp=0", bus.out_err); end
    checks++; if (bus.acc_val !== 4'd0) begin errors++; $display("FAIL rst_acc got=%0d exp=0", bus.acc_val); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0d exp=1", bus.in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_rel_valid got=%0d exp=0", bus.out_valid); end
  endtask

  task automatic test_add();
    idle();
    @(negedge clk);
    drive(1'b1, SEL_ADD, 4'd9, 4'd7, 4'd13);
    @(negedge clk);
    idle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_latency got=%0d exp=0", bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%0d exp=1", bus.out_valid); end
    checks++; if (bus.tdout !== 6'd16) begin errors++; $display("FAIL add_tdout got=%0d exp=16", bus.tdout); end
    checks++; if (bus.tcmp !== 2'b01) begin errors++; $display("FAIL add_tcmp got=%0b exp=01", bus.tcmp); end
    checks++; if (bus.dout !== 4'd3) begin errors++; $display("FAIL add_dout got=%0d exp=3", bus.dout); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL add_err got=%0d exp=0", bus.out_err); end
  endtask

  task automatic test_sub();
    idle();
    @(negedge clk);
    drive(1'b1, SEL_SUB, 4'd3, 4'd9, 4'd13);
    @(negedge clk);
    drive(1'b1, SEL_SUB, 4'd9, 4'd3, 4'd13);
    @(negedge clk);
    idle();
    checks++; if (bus.tdout !== 6'b111010) begin errors++; $display("FAIL sub_neg_tdout got=%0b exp=111010", bus.tdout); end
    checks++; if (bus.tcmp !== 2'b10) begin errors++; $display("FAIL sub_neg_tcmp got=%0b exp=10", bus.tcmp); end
    checks++; if (bus.dout !== 4'd7) begin errors++; $display("FAIL sub_neg_dout got=%0d exp=7", bus.dout); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sub_pos_valid got=%0d exp=1", bus.out_valid); end
    checks++; if (bus.tcmp !== 2'b00) begin errors++; $display("FAIL sub_pos_tcmp got=%0b exp=00", bus.tcmp); end
    checks++; if (bus.dout !== 4'd6) begin errors++; $display("FAIL sub_pos_dout got=%0d exp=6", bus.dout); end
  endtask

  task automatic test_acc();
    idle();
    @(negedge clk);
    drive(1'b1, SEL_ACC_LOAD, 4'd5, 4'd0, 4'd13);
    @(negedge clk);
    drive(1'b1, SEL_ACC_ADD, 4'd10, 4'd0, 4'd13);
    @(negedge clk);
    drive(1'b1, SEL_ACC_ADD, 4'd12, 4'd0, 4'd13);
    checks++; if (bus.dout !== 4'd5) begin errors++; $display("FAIL acc_load_dout got=%0d exp=5", bus.dout); end
    @(negedge clk);
    idle();
    checks++; if (bus.dout !== 4'd2) begin errors++; $display("FAIL acc_add1_dout got=%0d exp=2", bus.dout); end
    checks++; if (bus.tdout !== 6'd15) begin errors++; $display("FAIL acc_add1_tdout got=%0d exp=15", bus.tdout); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL acc_add2_valid got=%0d exp=1", bus.out_valid); end
    checks++; if (bus.dout !== 4'd1) begin errors++; $display("FAIL acc_add2_dout got=%0d exp=1", bus.dout); end
    checks++; if (bus.tdout !== 6'd14) begin errors++; $display("FAIL acc_add2_tdout got=%0d exp=14", bus.tdout); end
    checks++; if (bus.acc_val !== 4'd1) begin errors++; $display("FAIL acc_val got=%0d exp=1", bus.acc_val); end
  endtask

  task automatic test_backpressure();
    idle();
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b1, SEL_ADD, 4'd4, 4'd5, 4'd13);
    @(negedge clk);
    drive(1'b1, SEL_ADD, 4'd12, 4'd12, 4'd13);
    @(negedge clk);
    drive(1'b0, SEL_ADD, 4'd0, 4'd0, 4'd13);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%0d exp=0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%0d exp=1", i, bus.out_valid); end
      checks++; if (bus.dout !== 4'd9) begin errors++; $display("FAIL bp_dout[%0d] got=%0d exp=9", i, bus.dout); end
      if (i < 2) @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got=%0d exp=1", bus.out_valid); end
    checks++; if (bus.dout !== 4'd11) begin errors++; $display("FAIL bp_second_dout got=%0d exp=11", bus.dout); end
    checks++; if (bus.tdout !== 6'd24) begin errors++; $display("FAIL bp_second_tdout got=%0d exp=24", bus.tdout); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%0d exp=0", bus.out_valid); end
  endtask

  task automatic test_err();
    idle();
    @(negedge clk);
    drive(1'b1, SEL_ADD, 4'd14, 4'd1, 4'd13);
    @(negedge clk);
    drive(1'b1, SEL_ACC_ADD, 4'd0, 4'd15, 4'd13);  // din2 out of range but ignored
    @(negedge clk);
    drive(1'b1, SEL_ADD, 4'd0, 4'd0, 4'd1);        // modulus below 2
    checks++; if (bus.out_err !== 1'b1) begin errors++; $display("FAIL err_flag got=%0d exp=1", bus.out_err); end
    checks++; if (bus.dout !== 4'd0) begin errors++; $display("FAIL err_dout got=%0d exp=0", bus.dout); end
    checks++; if (bus.tcmp !== 2'b00) begin errors++; $display("FAIL err_tcmp got=%0b exp=00", bus.tcmp); end
    checks++; if (bus.tdout !== 6'd15) begin errors++; $display("FAIL err_tdout got=%0d exp=15", bus.tdout); end
    @(negedge clk);
    idle();
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL err_acc_flag got=%0d exp=0", bus.out_err); end
    checks++; if (bus.dout !== 4'd1) begin errors++; $display("FAIL err_acc_dout got=%0d exp=1", bus.dout); end
    @(negedge clk);
    checks++; if (bus.out_err !== 1'b1) begin errors++; $display("FAIL err_q_small got=%0d exp=1", bus.out_err); end
    checks++; if (bus.acc_val !== 4'd1) begin errors++; $display("FAIL err_acc_kept got=%0d exp=1", bus.acc_val); end
  endtask

  task automatic test_clr();
    idle();
    @(negedge clk);
    drive(1'b1, SEL_ACC_ADD, 4'd4, 4'd0, 4'd13);
    bus.acc_clr = 1'b1;
    @(negedge clk);
    idle();
    checks++; if (bus.acc_val !== 4'd0) begin errors++; $display("FAIL clr_acc got=%0d exp=0", bus.acc_val); end
    @(negedge clk);
    checks++; if (bus.dout !== 4'd4) begin errors++; $display("FAIL clr_same_cycle_dout got=%0d exp=4", bus.dout); end
    checks++; if (bus.acc_val !== 4'd4) begin errors++; $display("FAIL clr_acc_after got=%0d exp=4", bus.acc_val); end
    drive(1'b1, SEL_ACC_ADD, 4'd3, 4'd0, 4'd13);
    @(negedge clk);
    idle();
    bus.acc_clr = 1'b1;
    @(negedge clk);
    bus.acc_clr = 1'b0;
    checks++; if (bus.dout !== 4'd7) begin errors++; $display("FAIL clr_win_dout got=%0d exp=7", bus.dout); end
    checks++; if (bus.acc_val !== 4'd0) begin errors++; $display("FAIL clr_win_acc got=%0d exp=0", bus.acc_val); end
  endtask

  task automatic test_reset_mid();
    idle();
    @(negedge clk);
    drive(1'b1, SEL_ACC_LOAD, 4'd6, 4'd0, 4'd13);
    @(negedge clk);
    drive(1'b1, SEL_ADD, 4'd1, 4'd2, 4'd13);
    @(negedge clk);
    idle();
    checks++; if (bus.acc_val !== 4'd6) begin errors++; $display("FAIL rm_acc_pre got=%0d exp=6", bus.acc_val); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rm_valid_pre got=%0d exp=1", bus.out_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%0d exp=0", bus.out_valid); end
    checks++; if (bus.acc_val !== 4'd0) begin errors++; $display("FAIL rm_acc got=%0d exp=0", bus.acc_val); end
    checks++; if (bus.dout !== 4'd0) begin errors++; $display("FAIL rm_dout got=%0d exp=0", bus.dout); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_stale[%0d] got=%0d exp=0", i, bus.out_valid); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_acc();
    test_backpressure();
    test_err();
    test_clr();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mas_pipe.md
Name: mas_pipe

Overview:
- Parametrised, pipelined modular adder/subtractor: computes (din1 ± din2) mod q for W-bit operands, or accumulates modulo q.
- Same raw-result / compare / correct structure as our 2-input MAS: raw sum/difference, range code tcmp, corrected dout.
- Adds width generalisation, 2-stage valid/ready pipeline, running modular accumulator and operand-range error flag.
- Sits between operand sources and downstream modular datapaths.

Parameters:
W, 4, operand/modulus width (unsigned); W >= 2

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
din1  in  W  operand 1, unsigned, must be < q
din2  in  W  operand 2, unsigned, must be < q (ignored in modes 10/11)
sel  in  2  00 add, 01 sub, 10 acc-add, 11 acc-load
q  in  W  modulus, must be >= 2; sampled per transaction
acc_clr  in  1  clear accumulator to 0
out_valid  out  1  output transaction valid
out_ready  in  1  downstream accepts output
tdout  out  W+2  signed raw (uncorrected) result
tcmp  out  2  00 in range [0,q), 01 raw >= q, 10 raw < 0
dout  out  W  corrected result in [0,q)
out_err  out  1  operand/modulus violation for this transaction
acc_val  out  W  current accumulator value

Behaviour:
- Clock/reset: one clock, clk; reset synchronous, active-low, port rst_n. While rst_n=0 at a clk edge: out_valid=0, both stage valids=0, tdout=0, tcmp=00, dout=0, out_err=0, acc=0. in_ready=1 after reset. Reset mid-operation discards in-flight transactions; no output is produced for them.
- Pipeline advance: adv = !out_valid || out_ready; in_ready = adv. Accept on in_valid && in_ready. Holding out_valid=1 with out_ready=0 freezes every stage; outputs stay stable.
- Stage 1 register (at accept):
  - Latches q, sel and the err check (din1>=q, or din2>=q for sel 0x, or q<2).
  - Raw result, signed W+2:
    - add: din1+din2
    - sub: din1-din2
    - acc-add: acc_eff+din1
    - acc-load: din1
- Stage 2 register (on adv), using mod_correct:
  - tcmp = 01 if raw>=q; 10 if raw<0; else 00.
  - dout = raw-q, raw+q or raw respectively.
  - tdout = raw, out_err latched, out_valid = stage-1 valid.
- Error transaction: out_err=1, dout=0, tcmp=00, accumulator unchanged. tdout still shows raw.
- Latency: 2 cycles accept-to-out_valid with no backpressure; throughput 1 per cycle.
- Accumulator:
  - acc <= dout_next when a non-error acc-add/acc-load transaction is captured into stage 2.
  - acc_eff = stage-1 corrected value when stage 1 holds a valid non-error acc op advancing this cycle (forwarding), else acc.
  - Back-to-back acc-add ops see each preceding result.
- acc_clr:
  - Clears acc at the edge.
  - If asserted in the same cycle as an acc op capture, clear wins.
  - An acc op accepted in the same cycle as acc_clr uses acc_eff=0.
- acc_val = acc register.
- Raw range for legal operands: [-(q-1), 2q-2]. W+2 signed covers it with no overflow. At most one correction step is needed.

Decomposition:
- Package mas_pkg: sel encodings (SEL_ADD, SEL_SUB, SEL_ACC_ADD, SEL_ACC_LOAD), tcmp encodings (TCMP_IN, TCMP_HI, TCMP_LO).
- Sub-module mod_correct (combinational, parameter W): inputs raw and q, outputs tcmp and dout. Instantiated in stage 2; its output also drives the forwarding path.

Test Plan:
- W=4, q=13, add 9,7 -> 2 cycles later tdout=16, tcmp=01, dout=3, out_err=0.
- q=13, sub 3,9 -> tdout=-6, tcmp=10, dout=7; sub 9,3 -> tcmp=00, dout=6.
- q=13, back-to-back acc-load 5, acc-add 10, acc-add 12, no bubbles -> dout 5, 2, 1; acc_val=1 after last.
- Hold out_ready=0 for 3 cycles with 2 ops in flight -> in_ready=0, outputs frozen; release -> both ops emerge in order, none lost or duplicated.
- q=13, add 14,1 -> out_err=1, dout=0; following acc-add 0 -> dout equals prior acc_val.
- Assert rst_n=0 one cycle with 2 ops in flight -> out_valid=0 next cycle, acc_val=0, no stale outputs after release.
